// File: rtl/efuse_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : efuse_seq_pkg
//  Purpose  : Shared types and constants for the eFuse sequencer: state
//             encoding, CSR bit positions, region decode and counter width.
//  Revision : 1.0  initial release
// ============================================================================
package efuse_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_SETUP = 3'd1,
        ST_RD_SENSE = 3'd2,
        ST_WR_SCAN  = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_GAP   = 3'd5,
        ST_ACK      = 3'd6
    } state_t;

    // CSR bit positions
    localparam int c_CSR_PGM_EN = 0;
    localparam int c_CSR_ERR    = 1;

    // Value of adr[8] that selects the CSR rather than the fuse array
    localparam logic c_REGION_CSR = 1'b1;

    // Width of the shared timing counter
    localparam int c_CNT_W = 16;

    // Assemble the zero-extended CSR read word
    function automatic logic [31:0] csr_word(input logic pgm_en, input logic err);
        logic [31:0] w;
        w               = '0;
        w[c_CSR_PGM_EN] = pgm_en;
        w[c_CSR_ERR]    = err;
        return w;
    endfunction

endpackage : efuse_seq_pkg
`default_nettype wire

// File: rtl/efuse_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : efuse_seq_timer
//  Purpose  : Loadable down-counter shared by every timed sequencer state.
//             Loading N-1 makes o_done rise after exactly N clocks.
//  Revision : 1.0  initial release
// ============================================================================
module efuse_seq_timer
    import efuse_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [c_CNT_W-1:0] i_value,
    output logic [c_CNT_W-1:0] o_value,
    output logic               o_done
);

    logic [c_CNT_W-1:0] r_count;

    // Load takes priority; otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_value = r_count;
    assign o_done  = (r_count == '0);

endmodule : efuse_seq_timer
`default_nettype wire

// File: rtl/efuse_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : efuse_seq_ctrl
//  Purpose  : Wishbone slave that sequences reads (setup + sense strobe) and
//             bit-serial programming pulses of a 64x8 eFuse array, plus a
//             small CSR holding the program enable and a sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module efuse_seq_ctrl
    import efuse_seq_pkg::*;
#(
    parameter int PGM_CYCLES = 200,
    parameter int PGM_GAP    = 4,
    parameter int RD_SETUP   = 2,
    parameter int RD_STROBE  = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [8:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [5:0]  fuse_addr,
    output logic [2:0]  fuse_bit,
    output logic        fuse_pgm,
    output logic        fuse_rd,
    input  logic [7:0]  fuse_q
);

    localparam logic [c_CNT_W-1:0] c_PGM_LD    = c_CNT_W'(PGM_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD    = c_CNT_W'(PGM_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(RD_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(RD_STROBE - 1);

    state_t              r_state;
    logic [2:0]          r_bit;
    logic [7:0]          r_wdat;
    logic [5:0]          r_fuse_addr;
    logic [2:0]          r_fuse_bit;
    logic                r_fuse_pgm;
    logic                r_fuse_rd;
    logic                r_ack;
    logic [31:0]         r_dat_o;
    logic                r_pgm_en;
    logic                r_err;
    logic                r_abort;

    logic                w_accept;
    logic                w_csr;
    logic                w_tmr_load;
    logic [c_CNT_W-1:0]  w_tmr_value;
    logic [c_CNT_W-1:0]  w_tmr_count;
    logic                w_tmr_done;
    logic                w_unused_ok;

    assign w_accept = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_csr    = (wb_adr_i[8] == c_REGION_CSR);

    // Bits of the bus that carry no meaning for this slave
    assign w_unused_ok = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1], w_tmr_count};

    efuse_seq_timer u_timer (
        .clk     (clock),
        .rst_n   (resetb),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_value (w_tmr_count),
        .o_done  (w_tmr_done)
    );

    // Timer reload on entry to each timed state (same edge as the transition)
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_csr && !wb_we_i) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_SETUP_LD;
                end
            end
            ST_RD_SETUP: begin
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_STROBE_LD;
                end
            end
            ST_WR_SCAN: begin
                if (r_wdat[r_bit]) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_PGM_LD;
                end
            end
            ST_WR_PULSE: begin
                if (w_tmr_done) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_GAP_LD;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered bus and fuse-array outputs
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state     <= ST_IDLE;
            r_bit       <= '0;
            r_wdat      <= '0;
            r_fuse_addr <= '0;
            r_fuse_bit  <= '0;
            r_fuse_pgm  <= 1'b0;
            r_fuse_rd   <= 1'b0;
            r_ack       <= 1'b0;
            r_dat_o     <= '0;
            r_pgm_en    <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_csr) begin
                            if (wb_we_i) begin
                                if (wb_sel_i[0]) begin
                                    r_pgm_en <= wb_dat_i[c_CSR_PGM_EN];
                                    if (wb_dat_i[c_CSR_ERR]) begin
                                        r_err <= 1'b0;
                                    end
                                end
                            end else begin
                                r_dat_o <= csr_word(r_pgm_en, r_err);
                            end
                            r_state <= ST_ACK;
                        end else if (!wb_we_i) begin
                            r_fuse_addr <= wb_adr_i[7:2];
                            r_state     <= ST_RD_SETUP;
                        end else if (!wb_sel_i[0]) begin
                            r_state <= ST_ACK;
                        end else if (!r_pgm_en) begin
                            // Attempt to blow fuses while locked is flagged
                            if (wb_dat_i[7:0] != 8'd0) begin
                                r_err <= 1'b1;
                            end
                            r_state <= ST_ACK;
                        end else begin
                            r_fuse_addr <= wb_adr_i[7:2];
                            r_wdat      <= wb_dat_i[7:0];
                            r_bit       <= '0;
                            r_abort     <= 1'b0;
                            r_state     <= ST_WR_SCAN;
                        end
                    end
                end
                ST_RD_SETUP: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_tmr_done) begin
                        r_fuse_rd <= 1'b1;
                        r_state   <= ST_RD_SENSE;
                    end
                end
                ST_RD_SENSE: begin
                    if (!wb_cyc_i) begin
                        r_fuse_rd <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_tmr_done) begin
                        r_dat_o   <= {24'd0, fuse_q};
                        r_fuse_rd <= 1'b0;
                        r_state   <= ST_ACK;
                    end
                end
                ST_WR_SCAN: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_wdat[r_bit]) begin
                        r_fuse_pgm <= 1'b1;
                        r_fuse_bit <= r_bit;
                        r_state    <= ST_WR_PULSE;
                    end else if (r_bit == 3'd7) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
                ST_WR_PULSE: begin
                    // A started pulse always runs to full width; an abort is
                    // remembered and honoured once the pulse ends
                    if (!wb_cyc_i) begin
                        r_abort <= 1'b1;
                    end
                    if (w_tmr_done) begin
                        r_fuse_pgm <= 1'b0;
                        if (r_abort || !wb_cyc_i) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WR_GAP;
                        end
                    end
                end
                ST_WR_GAP: begin
                    if (!wb_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_tmr_done) begin
                        if (r_bit == 3'd7) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_state <= ST_WR_SCAN;
                        end
                    end
                end
                ST_ACK: begin
                    r_ack   <= wb_cyc_i;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o  = r_dat_o;
    assign wb_ack_o  = r_ack;
    assign fuse_addr = r_fuse_addr;
    assign fuse_bit  = r_fuse_bit;
    assign fuse_pgm  = r_fuse_pgm;
    assign fuse_rd   = r_fuse_rd;

endmodule : efuse_seq_ctrl
`default_nettype wire

// File: tb/tb_efuse_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_efuse_seq_ctrl
//  Purpose  : Directed self-checking bench for efuse_seq_ctrl with default
//             timing parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_efuse_seq_ctrl;

    logic        clock;
    logic        resetb;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [8:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [5:0]  fuse_addr;
    logic [2:0]  fuse_bit;
    logic        fuse_pgm;
    logic        fuse_rd;
    logic [7:0]  fuse_q;

    int n_vec;
    int n_err;

    // per-transaction observations
    int idx;
    int n_pulse;
    int pgm_cycles;
    int pgm_first;
    int cur_len;
    int len_min;
    int len_max;
    int bitmask;
    int rd_first;
    int rd_cycles;
    int exp_addr;
    logic overlap;
    logic addr_bad;
    logic ack_seen;
    logic prev_pgm;

    int          lat;
    logic [31:0] rdat;

    efuse_seq_ctrl dut (
        .clock     (clock),
        .resetb    (resetb),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .fuse_addr (fuse_addr),
        .fuse_bit  (fuse_bit),
        .fuse_pgm  (fuse_pgm),
        .fuse_rd   (fuse_rd),
        .fuse_q    (fuse_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        idx        = -1;
        n_pulse    = 0;
        pgm_cycles = 0;
        pgm_first  = -1;
        cur_len    = 0;
        len_min    = 99999;
        len_max    = 0;
        bitmask    = 0;
        rd_first   = -1;
        rd_cycles  = 0;
        overlap    = 1'b0;
        addr_bad   = 1'b0;
        ack_seen   = 1'b0;
        prev_pgm   = fuse_pgm;
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        idx++;
        if (fuse_pgm && fuse_rd) overlap = 1'b1;
        if (wb_ack_o) ack_seen = 1'b1;
        if (fuse_pgm) begin
            pgm_cycles++;
            cur_len++;
            if (!prev_pgm) begin
                n_pulse++;
                bitmask = bitmask | (1 << fuse_bit);
                if (pgm_first < 0) pgm_first = idx;
            end
            if (fuse_addr != 6'(exp_addr)) addr_bad = 1'b1;
        end else if (prev_pgm) begin
            if (cur_len < len_min) len_min = cur_len;
            if (cur_len > len_max) len_max = cur_len;
            cur_len = 0;
        end
        if (fuse_rd) begin
            rd_cycles++;
            if (rd_first < 0) rd_first = idx;
            if (fuse_addr != 6'(exp_addr)) addr_bad = 1'b1;
        end
        prev_pgm = fuse_pgm;
    endtask

    // One bus cycle; lat = edges after the accept edge at which ack is seen
    task automatic xfer(input logic we, input logic [8:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int o_lat, output logic [31:0] o_rdat);
        clear_stats();
        o_lat    = -1;
        o_rdat   = 32'hDEAD_BEEF;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (wb_ack_o) begin
                o_lat  = idx;
                o_rdat = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        resetb   = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_adr_i = 9'h0;
        wb_dat_i = 32'h0;
        fuse_q   = 8'hA5;
        exp_addr = 0;
        clear_stats();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pgm",  {31'd0, fuse_pgm}, 32'd0);
        chk("rst_rd",   {31'd0, fuse_rd}, 32'd0);
        chk("rst_ack",  {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat",  wb_dat_o, 32'd0);
        chk("rst_addr", {26'd0, fuse_addr}, 32'd0);
        resetb = 1'b1;
        tick();

        // Fuse read of byte 5
        exp_addr = 5;
        xfer(1'b0, {1'b0, 6'd5, 2'b00}, 32'h0, 4'h1, lat, rdat);
        chk("rd_lat",      32'(lat), 32'd7);
        chk("rd_data",     rdat, 32'h0000_00A5);
        chk("rd_first",    32'(rd_first), 32'd2);
        chk("rd_width",    32'(rd_cycles), 32'd4);
        chk("rd_addr_ok",  {31'd0, addr_bad}, 32'd0);
        chk("rd_no_pgm",   32'(n_pulse), 32'd0);

        // Enable programming and read CSR back
        xfer(1'b1, 9'h100, 32'h1, 4'h1, lat, rdat);
        chk("csr_wr_lat",  32'(lat), 32'd1);
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("csr_rd_lat",  32'(lat), 32'd1);
        chk("csr_pgm_en",  rdat, 32'h1);

        // Program 0x81 into byte 63
        exp_addr = 63;
        xfer(1'b1, {1'b0, 6'd63, 2'b00}, 32'h81, 4'h1, lat, rdat);
        chk("wr81_lat",    32'(lat), 32'd417);
        chk("wr81_pulses", 32'(n_pulse), 32'd2);
        chk("wr81_bits",   32'(bitmask), 32'h81);
        chk("wr81_first",  32'(pgm_first), 32'd1);
        chk("wr81_minw",   32'(len_min), 32'd200);
        chk("wr81_maxw",   32'(len_max), 32'd200);
        chk("wr81_addr",   {31'd0, addr_bad}, 32'd0);
        chk("wr81_excl",   {31'd0, overlap}, 32'd0);

        // Program 0x00: scan only
        xfer(1'b1, {1'b0, 6'd7, 2'b00}, 32'h00, 4'h1, lat, rdat);
        chk("wr00_lat",    32'(lat), 32'd9);
        chk("wr00_pulses", 32'(n_pulse), 32'd0);

        // Disable programming, attempt a blow -> err
        xfer(1'b1, 9'h100, 32'h0, 4'h1, lat, rdat);
        xfer(1'b1, {1'b0, 6'd3, 2'b00}, 32'h01, 4'h1, lat, rdat);
        chk("lock_lat",    32'(lat), 32'd1);
        chk("lock_pulses", 32'(n_pulse), 32'd0);
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("csr_err",     rdat, 32'h2);
        xfer(1'b1, 9'h100, 32'h2, 4'h1, lat, rdat);
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("csr_w1c",     rdat, 32'h0);

        // Write with byte lane 0 disabled: no effect, no err
        xfer(1'b1, {1'b0, 6'd3, 2'b00}, 32'hFF, 4'hE, lat, rdat);
        chk("nosel_lat",   32'(lat), 32'd1);
        chk("nosel_pgm",   32'(n_pulse), 32'd0);
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("nosel_csr",   rdat, 32'h0);

        // Drop cyc 50 cycles into the bit-0 pulse of an 0x03 write
        xfer(1'b1, 9'h100, 32'h1, 4'h1, lat, rdat);
        exp_addr = 10;
        clear_stats();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {1'b0, 6'd10, 2'b00};
        wb_dat_i = 32'h03;
        wb_sel_i = 4'h1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fuse_pgm) break;
        end
        chk("drop_rise",   32'(pgm_first), 32'd1);
        repeat (49) tick();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (600) tick();
        chk("drop_pulses", 32'(n_pulse), 32'd1);
        chk("drop_width",  32'(pgm_cycles), 32'd200);
        chk("drop_noack",  {31'd0, ack_seen}, 32'd0);
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("drop_idle",   32'(lat), 32'd1);
        chk("drop_csr",    rdat, 32'h1);

        // Asynchronous reset in the middle of a pulse
        exp_addr = 2;
        clear_stats();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {1'b0, 6'd2, 2'b00};
        wb_dat_i = 32'h01;
        wb_sel_i = 4'h1;
        repeat (20) tick();
        chk("arst_pre",    {31'd0, fuse_pgm}, 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_pgm",    {31'd0, fuse_pgm}, 32'd0);
        chk("arst_addr",   {26'd0, fuse_addr}, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        resetb = 1'b1;
        @(posedge clock);
        #1;
        xfer(1'b0, 9'h100, 32'h0, 4'h1, lat, rdat);
        chk("arst_csr",    rdat, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_efuse_seq_ctrl
`default_nettype wire
